// File: rtl/ula_scheduler.sv
// Two-port round-robin scheduler in front of the shared combinational ULA.
// It has an issue stage and a one-entry response buffer. Define ULA_SCHED_FIXED_PRIO_EN to give port 0 fixed priority.
module ula_scheduler #(
    parameter int WIDTH = 32,
    parameter int OPW   = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_A,
    input  logic [WIDTH-1:0] req0_B,
    input  logic [OPW-1:0]   req0_opcode,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_A,
    input  logic [WIDTH-1:0] req1_B,
    input  logic [OPW-1:0]   req1_opcode,
    output logic             req1_ready,
    output logic [WIDTH-1:0] ula_A,
    output logic [WIDTH-1:0] ula_B,
    output logic [OPW-1:0]   ula_opcode,
    input  logic [WIDTH-1:0] ula_Out,
    input  logic             ula_Flag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_Out,
    output logic             rsp_Flag,
    output logic             idle
);

    logic s1_valid;
    logic s1_id;
    logic s1_free;
    logic s2_free;
    logic grant;
    logic accept0;
    logic accept1;
    logic accept;

    assign s2_free = !rsp_valid || rsp_ready;
    assign s1_free = !s1_valid || s2_free;

`ifdef ULA_SCHED_FIXED_PRIO_EN
    // Port 1 is granted only when port 0 is not requesting.
    always_comb begin
        grant = 1'b0;
        if (!req0_valid && req1_valid) begin
            grant = 1'b1;
        end
    end
`else
    logic last_grant;

    // A contended grant goes to the port that did not win last time.
    // With no requester, the grant parks on that same port.
    always_comb begin
        grant = ~last_grant;
        if (req0_valid && !req1_valid) begin
            grant = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grant = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant;
        end
    end
`endif

    assign req0_ready = s1_free && (grant == 1'b0);
    assign req1_ready = s1_free && (grant == 1'b1);
    assign accept0    = req0_valid && req0_ready;
    assign accept1    = req1_valid && req1_ready;
    assign accept     = accept0 || accept1;

    // Issue stage: the operand registers feed the ULA directly.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_id      <= 1'b0;
            ula_A      <= '0;
            ula_B      <= '0;
            ula_opcode <= '0;
        end else if (s1_free) begin
            s1_valid <= accept;
            if (accept1) begin
                s1_id      <= 1'b1;
                ula_A      <= req1_A;
                ula_B      <= req1_B;
                ula_opcode <= req1_opcode;
            end else if (accept0) begin
                s1_id      <= 1'b0;
                ula_A      <= req0_A;
                ula_B      <= req0_B;
                ula_opcode <= req0_opcode;
            end
        end
    end

    // The response buffer samples the ULA result when the issue stage moves forward.
    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_Out   <= '0;
            rsp_Flag  <= 1'b0;
        end else if (s2_free) begin
            rsp_valid <= s1_valid;
            if (s1_valid) begin
                rsp_id   <= s1_id;
                rsp_Out  <= ula_Out;
                rsp_Flag <= ula_Flag;
            end
        end
    end

    assign idle = !s1_valid && !rsp_valid;

endmodule

// File: tb/tb_ula_scheduler.sv
// Self-checking bench for ula_scheduler.
// It uses a queue-based reference model of in-flight operations and a behavioural ULA.
module tb_ula_scheduler;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [31:0] req0_A = '0, req0_B = '0, req1_A = '0, req1_B = '0;
    logic [4:0]  req0_opcode = '0, req1_opcode = '0;
    logic        req0_ready, req1_ready;
    logic [31:0] ula_A, ula_B, ula_Out;
    logic [4:0]  ula_opcode;
    logic        ula_Flag;
    logic        rsp_valid, rsp_id, rsp_Flag, idle;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_Out;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        id;
        logic [31:0] out;
        logic        flag;
    } op_t;

    op_t         q[$];
    bit          head_in_s2 = 0;
    bit          lg = 1;
    logic [31:0] e_A = '0, e_B = '0;
    logic [4:0]  e_op = '0;
    bit          vld0 = 0, vld1 = 0;
    logic [31:0] p0_A, p0_B, p1_A, p1_B;
    logic [4:0]  p0_op, p1_op;
    logic [31:0] n0_A, n0_B, n1_A, n1_B;
    logic [4:0]  n0_op, n1_op;

    function automatic logic [32:0] ula_f(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
        logic [31:0] r;
        case (op)
            5'd0:    r = a + b;
            5'd1:    r = a - b;
            5'd2:    r = a & b;
            5'd3:    r = a | b;
            5'd4:    r = a ^ b;
            default: r = a;
        endcase
        return {(r == 32'd0), r};
    endfunction

    assign {ula_Flag, ula_Out} = ula_f(ula_A, ula_B, ula_opcode);

    ula_scheduler #(.WIDTH(32), .OPW(5)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_A(req0_A), .req0_B(req0_B), .req0_opcode(req0_opcode), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_A(req1_A), .req1_B(req1_B), .req1_opcode(req1_opcode), .req1_ready(req1_ready),
        .ula_A(ula_A), .ula_B(ula_B), .ula_opcode(ula_opcode), .ula_Out(ula_Out), .ula_Flag(ula_Flag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_Out(rsp_Out), .rsp_Flag(rsp_Flag),
        .idle(idle)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_next0();
        n0_A = $urandom; n0_B = $urandom; n0_op = 5'($urandom_range(0, 7));
    endtask

    task automatic rand_next1();
        n1_A = $urandom; n1_B = $urandom; n1_op = 5'($urandom_range(0, 7));
    endtask

    // Each step is one clock cycle. A pending request stays valid until it is accepted.
    task automatic step(input bit w0, input bit w1, input bit rr, input bit rst);
        bit rv, s2free, s1free, g, r0, r1, a0, a1, pop, mv;
        int s1occ;
        logic [32:0] res;
        if (!vld0 && w0) begin
            vld0 = 1; p0_A = n0_A; p0_B = n0_B; p0_op = n0_op; rand_next0();
        end
        if (!vld1 && w1) begin
            vld1 = 1; p1_A = n1_A; p1_B = n1_B; p1_op = n1_op; rand_next1();
        end
        req0_valid = vld0; req0_A = vld0 ? p0_A : 32'hx; req0_B = vld0 ? p0_B : 32'hx;
        req0_opcode = vld0 ? p0_op : 5'hx;
        req1_valid = vld1; req1_A = vld1 ? p1_A : 32'hx; req1_B = vld1 ? p1_B : 32'hx;
        req1_opcode = vld1 ? p1_op : 5'hx;
        rsp_ready = rr;
        reset = rst;
        #1;
        rv = (q.size() > 0) && head_in_s2;
        s1occ = q.size() - (rv ? 1 : 0);
        s2free = !rv || rr;
        s1free = (s1occ == 0) || s2free;
`ifdef ULA_SCHED_FIXED_PRIO_EN
        g = !vld0 && vld1;
`else
        if (vld0 && !vld1) g = 0;
        else if (vld1 && !vld0) g = 1;
        else g = !lg;
`endif
        r0 = s1free && !g;
        r1 = s1free && g;
        check("req0_ready", 32'(req0_ready), 32'(r0));
        check("req1_ready", 32'(req1_ready), 32'(r1));
        check("idle", 32'(idle), 32'(q.size() == 0));
        check("rsp_valid", 32'(rsp_valid), 32'(rv));
        check("ula_A", ula_A, e_A);
        check("ula_B", ula_B, e_B);
        check("ula_opcode", 32'(ula_opcode), 32'(e_op));
        if (rv) begin
            check("rsp_id", 32'(rsp_id), 32'(q[0].id));
            check("rsp_Out", rsp_Out, q[0].out);
            check("rsp_Flag", 32'(rsp_Flag), 32'(q[0].flag));
        end
        a0 = vld0 && r0 && !rst;
        a1 = vld1 && r1 && !rst;
        @(posedge clock);
        #1;
        if (rst) begin
            q.delete(); head_in_s2 = 0; lg = 1; e_A = '0; e_B = '0; e_op = '0;
        end else begin
            pop = rv && rr;
            mv = (s1occ > 0) && s2free;
            if (pop) void'(q.pop_front());
            head_in_s2 = mv ? 1'b1 : (pop ? 1'b0 : head_in_s2);
            if (a0) begin
                res = ula_f(p0_A, p0_B, p0_op);
                q.push_back('{id: 1'b0, out: res[31:0], flag: res[32]});
                e_A = p0_A; e_B = p0_B; e_op = p0_op; lg = 0; vld0 = 0;
            end else if (a1) begin
                res = ula_f(p1_A, p1_B, p1_op);
                q.push_back('{id: 1'b1, out: res[31:0], flag: res[32]});
                e_A = p1_A; e_B = p1_B; e_op = p1_op; lg = 1; vld1 = 0;
            end
        end
    endtask

    initial begin
        rand_next0();
        rand_next1();
        @(posedge clock);
        #1;
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        // Reset state.
        check("rst_rsp_Out", rsp_Out, 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);

        // Single operation: A=1, B=0, opcode=0.
        n0_A = 32'd1; n0_B = 32'd0; n0_op = 5'd0;
        step(1, 0, 1, 0);
        check("single_ula_A", ula_A, 32'd1);
        step(0, 0, 1, 0);
        check("single_rsp_valid", 32'(rsp_valid), 32'd1);
        check("single_rsp_Out", rsp_Out, 32'd1);
        check("single_rsp_Flag", 32'(rsp_Flag), 32'd0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);

        // Contention: both ports stay valid for four cycles.
        for (int i = 0; i < 4; i++) begin
            n1_A = 32'd5; n1_B = 32'd0; n1_op = 5'd1;
            step(1, 1, 1, 0);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);

        // Backpressure: the pipeline fills and freezes, then drains.
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        check("bp_req0_ready", 32'(req0_ready), 32'd0);
        // Pop and push in the same cycle while the pipeline is full.
        step(0, 1, 1, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);

        // Reset mid-flight.
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(0, 0, 0, 1);
        check("mid_rst_idle", 32'(idle), 32'd1);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_ula_A", ula_A, 32'd0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);

        // Idle and pointer hold: the next contention must grant port 0.
        step(0, 1, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        check("hold_idle", 32'(idle), 32'd1);
        step(1, 1, 1, 0);
        step(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 99) == 0);
        end
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
